// File: rtl/ram_reader_pkg.sv
// Shared definitions for the RAM read sequencer and its write-path partner:
// FSM state encoding and default RAM geometry / hold time.
package ram_reader_pkg;

  localparam int DEF_ADDR_WIDTH  = 2;
  localparam int DEF_DATA_WIDTH  = 2;
  localparam int DEF_HOLD_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPT,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/ram_reader.sv
// Sweeps the whole RAM on start, presenting each word for HOLD_CYCLES cycles.
// Define RAM_READER_CKSUM_EN to build the running XOR checksum of captured words.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [7:0]            HOLD_INIT = 8'(HOLD_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              hold_cnt;
  logic                    hold_zero;
  logic                    last_word;

  assign hold_zero = (hold_cnt == 8'd0);
  assign last_word = (addr_q == LAST_ADDR);

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     state_nxt = CAPT;
      CAPT:    state_nxt = HOLD;
      HOLD:    if (hold_zero) state_nxt = last_word ? DONE : REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Terminal address is tested before increment, so addr_q never wraps in a sweep.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) addr_q <= '0;
        CAPT: hold_cnt <= HOLD_INIT;
        HOLD: begin
          if (!hold_zero)      hold_cnt <= hold_cnt - 8'd1;
          else if (!last_word) addr_q   <= addr_q + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      out_addr <= '0;
      out_data <= '0;
    end else if (state == CAPT) begin
      out_addr <= addr_q;
      out_data <= ram_rdata;
    end
  end

`ifdef RAM_READER_CKSUM_EN
  logic [DATA_WIDTH-1:0] cksum_q;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset)                      cksum_q <= '0;
    else if (state == IDLE && start) cksum_q <= '0;
    else if (state == CAPT)          cksum_q <= cksum_q ^ ram_rdata;
  end

  assign checksum = cksum_q;
`else
  assign checksum = '0;
`endif

  assign ram_addr  = addr_q;
  assign ram_rd_en = (state == REQ);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_ram_reader.sv
// Scoreboard bench for ram_reader: stimulus pushes expected words and sweep
// timing; a negedge monitor compares every cycle against those expectations.
module tb_ram_reader;

  localparam int AW = 2;
  localparam int DW = 2;
  localparam int H  = 2;
  localparam int N  = 1 << AW;
  localparam int P  = 2 + H;
  localparam int L  = N * P + 1;

  logic          clk_2 = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_rd_en;
  logic [DW-1:0] ram_rdata = '0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_CYCLES(H)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .start     (start),
    .ram_addr  (ram_addr),
    .ram_rd_en (ram_rd_en),
    .ram_rdata (ram_rdata),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk_2 = ~clk_2;

  // 1-cycle-latency synchronous RAM (ram_sync_1p behaviour)
  logic [DW-1:0] mem [N];
  always @(posedge clk_2) if (ram_rd_en) ram_rdata <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk_2) cyc <= cyc + 1;

  typedef struct { int addr; int data; } word_t;
  word_t words[$];
  int    cks[$];
  int    bases[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected behaviour of one sweep whose start is sampled at the edge ending cycle b.
  task automatic push_sweep(input int b);
    int x = 0;
    bases.push_back(b);
    for (int k = 0; k < N; k++) begin
      words.push_back('{addr: k, data: int'(mem[k])});
      x ^= int'(mem[k]);
    end
`ifdef RAM_READER_CKSUM_EN
    cks.push_back(x);
`else
    cks.push_back(0);
`endif
  endtask

  task automatic randomize_mem();
    for (int k = 0; k < N; k++) mem[k] = DW'($urandom);
  endtask

  // Monitor
  logic  prev_valid = 1'b0;
  int    last_addr = 0, last_data = 0;
  int    n, pos, widx;
  bit    in_word;
  word_t w;

  always @(negedge clk_2) begin
    if (reset) begin
      prev_valid = 1'b0;
      last_addr  = 0;
      last_data  = 0;
    end else begin
      n = -1;
      for (int i = 0; i < bases.size(); i++)
        if (cyc - bases[i] >= 1 && cyc - bases[i] <= L) n = cyc - bases[i];
      in_word = (n >= 1) && (n <= N * P);
      pos  = in_word ? (n - 1) % P : 0;
      widx = in_word ? (n - 1) / P : 0;
      check("busy", int'(busy), int'(n >= 1));
      check("done", int'(done), int'(n == L));
      check("ram_rd_en", int'(ram_rd_en), int'(in_word && pos == 0));
      check("out_valid", int'(out_valid), int'(in_word && pos >= 2));
      if (in_word && pos == 0) check("ram_addr", int'(ram_addr), widx);
      if (out_valid && !prev_valid) begin
        if (words.size() == 0) check("word_queue_nonempty", 0, 1);
        else begin
          w = words.pop_front();
          check("out_addr", int'(out_addr), w.addr);
          check("out_data", int'(out_data), w.data);
          last_addr = w.addr;
          last_data = w.data;
        end
      end else begin
        check("out_addr_stable", int'(out_addr), last_addr);
        check("out_data_stable", int'(out_data), last_data);
      end
      if (done) begin
        if (cks.size() == 0) check("done_expected", 0, 1);
        else check("checksum_at_done", int'(checksum), cks.pop_front());
      end
`ifndef RAM_READER_CKSUM_EN
      check("checksum_zero", int'(checksum), 0);
`endif
      prev_valid = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int b;

  initial begin
    for (int k = 0; k < N; k++) mem[k] = '0;
    repeat (3) @(negedge clk_2);
    #2 reset = 1'b0;

    // idle with start low
    repeat (10) @(negedge clk_2);

    // fixed contents {1,3,2,3}
    mem[0] = 2'd1; mem[1] = 2'd3; mem[2] = 2'd2; mem[3] = 2'd3;
    @(negedge clk_2); start = 1'b1; push_sweep(cyc);
    @(negedge clk_2); start = 1'b0;
    repeat (L + 2) @(negedge clk_2);

    // stray start in cycle 5 is ignored
    @(negedge clk_2); start = 1'b1; b = cyc; push_sweep(b);
    @(negedge clk_2); start = 1'b0;
    while (cyc < b + 5) @(negedge clk_2);
    start = 1'b1;
    @(negedge clk_2); start = 1'b0;
    while (cyc < b + L + 2) @(negedge clk_2);

    // random contents
    for (int s = 0; s < 4; s++) begin
      randomize_mem();
      @(negedge clk_2); start = 1'b1; push_sweep(cyc);
      @(negedge clk_2); start = 1'b0;
      repeat (L + 1 + $urandom_range(0, 3)) @(negedge clk_2);
    end

    // reset in cycle 7 aborts the sweep
    randomize_mem();
    @(negedge clk_2); start = 1'b1; b = cyc; push_sweep(b);
    @(negedge clk_2); start = 1'b0;
    while (cyc < b + 7) @(negedge clk_2);
    #2 reset = 1'b1;
    #1;
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_rd_en", int'(ram_rd_en), 0);
    check("rst_out_addr", int'(out_addr), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_checksum", int'(checksum), 0);
    words.delete();
    cks.delete();
    bases.delete();
    @(negedge clk_2);
    @(negedge clk_2);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk_2);
    randomize_mem();
    @(negedge clk_2); start = 1'b1; push_sweep(cyc);
    @(negedge clk_2); start = 1'b0;
    repeat (L + 2) @(negedge clk_2);

    // start held high: back-to-back sweeps with one IDLE cycle between
    randomize_mem();
    @(negedge clk_2); start = 1'b1; b = cyc;
    push_sweep(b);
    push_sweep(b + L + 1);
    while (cyc < b + L + 2) @(negedge clk_2);
    start = 1'b0;
    while (cyc < b + 2 * L + 4) @(negedge clk_2);

    check("words_drained", words.size(), 0);
    check("cksums_drained", cks.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_reader.md
# ram_reader

Autonomous read-side sequencer for the board's small single-port synchronous RAM. On a `start` pulse it sweeps every address from 0 to the top address, one word at a time. Each word is captured and presented on the LED/LCD debug outputs for a fixed number of `clk_2` cycles, then `done` is pulsed. It is the read-direction partner of the switch-driven write path and shares the same RAM geometry.

## Interface
Parameters:
- `ADDR_WIDTH`, default 2: RAM address width; the sweep covers 2**ADDR_WIDTH words.
- `DATA_WIDTH`, default 2: RAM word width.
- `HOLD_CYCLES`, default 2: cycles each word is held with `out_valid` high. Legal range is 1 to 255.

Ports:
- `clk_2`, input, 1: system clock. All registers update on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset; clock is `clk_2`.
- `start`, input, 1: sweep request. Sampled only in IDLE.
- `ram_addr`, output, ADDR_WIDTH: RAM read address.
- `ram_rd_en`, output, 1: RAM read strobe. High only in REQ.
- `ram_rdata`, input, DATA_WIDTH: RAM read data. Valid exactly one cycle after the `ram_rd_en` cycle.
- `out_addr`, output, ADDR_WIDTH: address of the word currently presented.
- `out_data`, output, DATA_WIDTH: captured word.
- `out_valid`, output, 1: high throughout HOLD.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse in DONE.
- `checksum`, output, DATA_WIDTH: running XOR of captured words (see Configuration).

## Operation
FSM states: IDLE, REQ, CAPT, HOLD, DONE.
- IDLE: `start`=1 clears `addr_q` and the checksum, then moves to REQ. `start`=0 stays in IDLE.
- REQ: `ram_rd_en`=1 and `ram_addr`=`addr_q`. Always moves to CAPT.
- CAPT: at the end of the cycle, `out_data`<=`ram_rdata`, `out_addr`<=`addr_q`, checksum ^= `ram_rdata`, and `hold_cnt`<=HOLD_CYCLES-1. Moves to HOLD.
- HOLD: `out_valid`=1. While `hold_cnt`!=0, decrement it. When `hold_cnt`==0:
  - if `addr_q`==2**ADDR_WIDTH-1, go to DONE;
  - otherwise `addr_q`++ and go to REQ.
- DONE: `done`=1 for one cycle, then go to IDLE.

Boundary conditions:
- `start` is ignored in every non-IDLE state; it is neither queued nor restarts the sweep.
- `start` held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- `addr_q` never wraps inside a sweep. The terminal address is detected before increment.
- `ram_addr` equals `addr_q` in all states. Only `ram_rd_en` qualifies a read.
- Reset asserted mid-sweep aborts immediately. No `done` pulse is produced.
- Reset values: state=IDLE, `ram_addr`=0, `ram_rd_en`=0, `out_addr`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `checksum`=0.
- The block never writes the RAM. If the write path modifies a word during a sweep, the value read is whatever the RAM returns in CAPT.

## Timing
- `start` sampled high at edge E: REQ in the cycle after E, CAPT in the next cycle, HOLD in the one after that.
- Per word: 2+HOLD_CYCLES cycles.
- Full sweep: 2**ADDR_WIDTH × (2+HOLD_CYCLES) cycles, then one DONE cycle. With defaults: 16 cycles plus DONE, so `done` is high in cycle 17 after E.
- `out_data`/`out_addr` change only at the end of CAPT. They remain stable from then until the next CAPT, including after DONE.
- `busy` rises on the cycle after E and falls on the cycle after DONE.

## Configuration
- `RAM_READER_CKSUM_EN` defined:
  - checksum register and XOR accumulation are compiled in;
  - `checksum` is cleared on an accepted `start` and updated in each CAPT;
  - `checksum` holds the final value from DONE onward.
- `RAM_READER_CKSUM_EN` not defined:
  - no checksum register is built;
  - `checksum` is tied to 0;
  - all other behaviour is identical.

## Structure
- Shared package `ram_reader_pkg` holds:
  - the `state_t` enum (IDLE, REQ, CAPT, HOLD, DONE);
  - default constants for ADDR_WIDTH, DATA_WIDTH and HOLD_CYCLES, shared with the write path.
- No RTL sub-module; FSM, counters and capture registers live in one module.
- The bench provides `ram_sync_1p`, a 1-cycle-latency synchronous RAM model.

## Test plan
- Reset, then idle with `start`=0 for 10 cycles: all outputs stay at their reset values; `ram_rd_en` never rises.
- Defaults, preload RAM {1,3,2,3}, pulse `start`:
  - `out_addr`/`out_data` present 0/1, 1/3, 2/2, 3/3, each with `out_valid` high for 2 cycles;
  - `done` is high in cycle 17;
  - `busy` is high in cycles 1–17.
- Pulse `start` again in cycle 5 of an active sweep: no effect; sequence and `done` timing are identical to the previous case.
- Assert `reset` in cycle 7 of a sweep: all outputs return to reset values immediately; no `done`; a fresh `start` then sweeps from address 0.
- Hold `start` high continuously: after the first `done`, `busy` is low for exactly one IDLE cycle, then a new sweep begins at address 0.
- With `RAM_READER_CKSUM_EN` and RAM {1,3,2,3}: `checksum`=3 at `done`. Without the macro: `checksum` stays 0 throughout.
